lcd_stream_unpacker: RTL
========================

// Module: lcd_stream_unpacker
// PURPOSE
// - Read-side consumer of the 17-bit tagged frame stream that VideoController writes into the
//   output FIFO (FIFO_cam), on the FIFO read-clock domain (lcd_clock).
// - Pops words and checks the framing. Markers: 0x10000 frame start, 0x10001 row start,
//   0x1FFFF frame end; bit16=0 means a pixel.
// - Delivers bare RGB565 pixels with SOF/EOL/EOF flags over a valid/ready interface to the
//   LCD driver. On a framing violation it reports an error and resynchronises to the next frame.
// PARAMETERS
// - FRAME_WIDTH   23  pixels per row expected between row-start markers
// - FRAME_HEIGHT  17  rows per frame expected between frame start and frame end
// PORTS
// - clk              in   1   read-domain clock (FIFO RdClk)
// - rst_n            in   1   synchronous active-low reset
// - queue_empty      in   1   FIFO Empty
// - queue_data       in   17  FIFO Q; valid in the cycle after queue_rd_en=1
// - queue_rd_en      out  1   FIFO RdEn
// - pix_data         out  16  pixel value
// - pix_valid        out  1   pix_data and the flags are valid
// - pix_ready        in   1   sink accepts the beat when pix_valid & pix_ready
// - pix_sof          out  1   beat is pixel (0,0)
// - pix_eol          out  1   beat is the last pixel of a row
// - pix_eof          out  1   beat is the last pixel of the frame
// - error_o          out  1   one-cycle pulse on a framing violation
// - error_code       out  3   reason for the pulse; holds until the next error
// - frames_done      out  16  count of complete, clean frames; wraps
// BEHAVIOUR
// - Reset: every output 0; state WAIT_FRAME; counters 0; buffer empty.
// - Read issue: queue_rd_en = !queue_empty && (buf_count + inflight) < 2.
//   - inflight is 1 in the cycle after a read; that cycle's queue_data is captured.
//   - Never overrun the 2-entry buffer, even with pix_ready=0.
// - Captured word classes: FS, RS, FE, PIX (bit16=0), BAD (bit16=1, any other value).
// - Markers are consumed internally. Only PIX words enter the buffer, tagged with sof/eol/eof.
//   Throughput is 1 pixel/clk when the FIFO is non-empty and pix_ready=1.
// - Capture to pix_valid is 1 cycle when the buffer was empty.
// - FSM on each captured word (col 0..W-1, row 0..H-1):
//   - WAIT_FRAME: FS -> WAIT_ROW, row=0. Anything else is discarded silently.
//   - WAIT_ROW:
//     - RS -> PIXELS, col=0.
//     - FE with row==H -> WAIT_FRAME, frames_done++.
//     - FE with row<H -> ERR_SHORT_FRAME(3).
//     - PIX -> ERR_LONG_ROW(2).
//   - PIXELS, on PIX:
//     - Emit; sof = (row==0 && col==0), eol = (col==W-1), eof = eol && (row==H-1).
//     - col==W-1 -> row++, WAIT_ROW.
//   - PIXELS, RS/FE before col==W-1 -> ERR_SHORT_ROW(1).
//   - Any state, BAD -> ERR_BAD_MARKER(4).
//   - WAIT_ROW and PIXELS, RS with row==H -> ERR_LONG_FRAME(5).
// - On error: pulse error_o, latch error_code, go to WAIT_FRAME.
//   - Pixels already buffered are still delivered.
//   - Exception: FS received in WAIT_ROW/PIXELS logs ERR_UNEXPECTED_FS(6), then goes
//     directly to WAIT_ROW with row=0. The FS word is not lost.
// - FIFO empty mid-frame: stall, no error, no timeout.
// - pix_valid holds with stable data and flags until accepted (AXI-style; no retraction).
// - Reset mid-frame: buffer flushed; an in-flight FIFO word is discarded; restart in WAIT_FRAME.
// - Reset asserted with the FIFO non-empty: queue_rd_en=0 while rst_n=0.
// STRUCTURE
// - Shared package FrameUploaderTypes gains:
//   - constants STREAM_FRAME_START=17'h10000, STREAM_ROW_START=17'h10001,
//     STREAM_FRAME_END=17'h1FFFF;
//   - enum stream_err_t {ERR_NONE, ERR_SHORT_ROW, ERR_LONG_ROW, ERR_SHORT_FRAME,
//     ERR_BAD_MARKER, ERR_LONG_FRAME, ERR_UNEXPECTED_FS}.
//   VideoController uses the same constants.
// - Sub-module stream_skid_buffer: 2-entry, 19-bit-wide (pixel+3 flags) valid/ready buffer that
//   exports its count for read-issue gating.
// - Top level holds the FSM, counters and read-issue logic only.
// TESTING
// - Clean 23x17 frame with random pixels, pix_ready=1:
//   - 391 beats out, values in order;
//   - sof on beat 0, eol every 23rd beat, eof on beat 390;
//   - frames_done=1, error_o never pulses.
// - Same frame with pix_ready random at 50% and FIFO empty gaps inserted:
//   - identical beat sequence;
//   - no beat lost or duplicated, no FIFO read while buffer+inflight=2.
// - Row 5 truncated to 22 pixels:
//   - error_o pulses once with code 1;
//   - rows 0-4 plus 22 pixels delivered; the rest dropped until the next FS;
//   - a following clean frame gives frames_done=1.
// - 10 random words (including 0x1FFFF and 0x10001) before the first FS:
//   - all discarded, no error, frame decoded cleanly.
// - FS injected after row 8: code 6; the new frame decodes fully with sof on its first pixel.
// - rst_n low for 1 clk mid-row 3:
//   - pix_valid=0 and all outputs 0 in the next cycle;
//   - the next complete frame is decoded with frames_done=1.

Source files
------------

// File: rtl/lcd_stream_unpacker_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// FrameUploaderTypes: marker constants and types of the tagged frame stream.
// Rev 1.0
// ------------------------------------------------------------------------
package FrameUploaderTypes;

  localparam logic [16:0] STREAM_FRAME_START = 17'h10000;
  localparam logic [16:0] STREAM_ROW_START   = 17'h10001;
  localparam logic [16:0] STREAM_FRAME_END   = 17'h1FFFF;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_SHORT_ROW     = 3'd1,
    ERR_LONG_ROW      = 3'd2,
    ERR_SHORT_FRAME   = 3'd3,
    ERR_BAD_MARKER    = 3'd4,
    ERR_LONG_FRAME    = 3'd5,
    ERR_UNEXPECTED_FS = 3'd6
  } stream_err_t;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_WAIT_ROW   = 2'd1,
    ST_PIXELS     = 2'd2
  } stream_state_t;

  typedef enum logic [2:0] {
    WORD_PIX = 3'd0,
    WORD_FS  = 3'd1,
    WORD_RS  = 3'd2,
    WORD_FE  = 3'd3,
    WORD_BAD = 3'd4
  } word_class_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] data;
  } pix_beat_t;

  function automatic word_class_t classify_word(input logic [16:0] word);
    word_class_t cls;
    if (!word[16])                         cls = WORD_PIX;
    else if (word == STREAM_FRAME_START)   cls = WORD_FS;
    else if (word == STREAM_ROW_START)     cls = WORD_RS;
    else if (word == STREAM_FRAME_END)     cls = WORD_FE;
    else                                   cls = WORD_BAD;
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_stream_unpacker_skid_buffer.sv
`default_nettype none
// ------------------------------------------------------------------------
// stream_skid_buffer: 2-entry valid/ready buffer for tagged pixel beats.
// Rev 1.0
// ------------------------------------------------------------------------
module stream_skid_buffer
  import FrameUploaderTypes::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  pix_beat_t  in_beat,
  output logic       out_valid,
  output pix_beat_t  out_beat,
  input  logic       out_ready,
  output logic [1:0] level
);

  pix_beat_t  slot0_q, slot0_d;
  pix_beat_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       pop;
  logic [1:0] keep;

  // level is the occupancy left after this cycle's pop, so the read gate can
  // refill a slot that is being drained and sustain one beat per clock.
  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    keep    = count_q - {1'b0, pop};
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (pop) slot0_d = slot1_q;
    if (in_valid) begin
      if (keep == 2'd0) slot0_d = in_beat;
      else              slot1_d = in_beat;
    end
    count_d = keep + {1'b0, in_valid};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_beat  = slot0_q;
  assign level     = keep;

endmodule
`default_nettype wire

// File: rtl/lcd_stream_unpacker.sv
`default_nettype none
// ------------------------------------------------------------------------
// lcd_stream_unpacker: checks tagged FIFO frames, emits RGB565 beats. Rev 1.0
// ------------------------------------------------------------------------
module lcd_stream_unpacker
  import FrameUploaderTypes::*;
#(
  parameter int FRAME_WIDTH  = 23,
  parameter int FRAME_HEIGHT = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        error_o,
  output logic [2:0]  error_code,
  output logic [15:0] frames_done
);

  localparam int COL_W = $clog2(FRAME_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ALL_ROWS = ROW_W'(FRAME_HEIGHT);

  stream_state_t    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [15:0]      frames_done_q, frames_done_d;
  stream_err_t      error_code_q, error_code_d;
  logic             error_q, error_d;
  logic             inflight_q;
  logic             fault;
  stream_err_t      fault_code;
  word_class_t      word_cls;
  logic             push;
  pix_beat_t        push_beat;
  pix_beat_t        out_beat;
  logic [1:0]       buf_level;

  assign queue_rd_en = rst_n && !queue_empty && ((buf_level + {1'b0, inflight_q}) < 2'd2);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    frames_done_d = frames_done_q;
    error_code_d  = error_code_q;
    error_d       = 1'b0;
    fault         = 1'b0;
    fault_code    = ERR_NONE;
    push          = 1'b0;
    word_cls      = classify_word(queue_data);
    push_beat     = '{sof:  (row_q == '0) && (col_q == '0),
                      eol:  (col_q == LAST_COL),
                      eof:  (col_q == LAST_COL) && (row_q == LAST_ROW),
                      data: queue_data[15:0]};
    if (inflight_q) begin
      if (word_cls == WORD_BAD) begin
        fault      = 1'b1;
        fault_code = ERR_BAD_MARKER;
      end else if (word_cls == WORD_FS) begin
        // A stray FS is still a valid frame start: log it and adopt it.
        if (state_q != ST_WAIT_FRAME) begin
          error_d      = 1'b1;
          error_code_d = ERR_UNEXPECTED_FS;
        end
        state_d = ST_WAIT_ROW;
        row_d   = '0;
      end else begin
        case (state_q)
          ST_WAIT_ROW: begin
            if (word_cls == WORD_RS) begin
              if (row_q == ALL_ROWS) begin
                fault      = 1'b1;
                fault_code = ERR_LONG_FRAME;
              end else begin
                state_d = ST_PIXELS;
                col_d   = '0;
              end
            end else if (word_cls == WORD_FE) begin
              if (row_q == ALL_ROWS) begin
                state_d       = ST_WAIT_FRAME;
                frames_done_d = frames_done_q + 16'd1;
              end else begin
                fault      = 1'b1;
                fault_code = ERR_SHORT_FRAME;
              end
            end else begin
              fault      = 1'b1;
              fault_code = ERR_LONG_ROW;
            end
          end
          ST_PIXELS: begin
            if (word_cls == WORD_PIX) begin
              push = 1'b1;
              if (col_q == LAST_COL) begin
                row_d   = row_q + ROW_W'(1);
                state_d = ST_WAIT_ROW;
              end else begin
                col_d = col_q + COL_W'(1);
              end
            end else begin
              fault      = 1'b1;
              fault_code = ERR_SHORT_ROW;
            end
          end
          default: ;
        endcase
      end
    end
    if (fault) begin
      error_d      = 1'b1;
      error_code_d = fault_code;
      state_d      = ST_WAIT_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_FRAME;
      row_q         <= '0;
      col_q         <= '0;
      frames_done_q <= 16'd0;
      error_code_q  <= ERR_NONE;
      error_q       <= 1'b0;
      inflight_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frames_done_q <= frames_done_d;
      error_code_q  <= error_code_d;
      error_q       <= error_d;
      inflight_q    <= queue_rd_en;
    end
  end

  stream_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push),
    .in_beat   (push_beat),
    .out_valid (pix_valid),
    .out_beat  (out_beat),
    .out_ready (pix_ready),
    .level     (buf_level)
  );

  assign pix_data    = out_beat.data;
  assign pix_sof     = out_beat.sof;
  assign pix_eol     = out_beat.eol;
  assign pix_eof     = out_beat.eof;
  assign error_o     = error_q;
  assign error_code  = error_code_q;
  assign frames_done = frames_done_q;

endmodule
`default_nettype wire
